// File: rtl/muldiv_seq_pkg.sv
// Shared ALU op codes and muldiv_seq state encoding.
// Used by the combinational ALU and by muldiv_seq.
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MINUS = 4'b0110;
  localparam logic [3:0] ALU_MUL   = 4'b0011;
  localparam logic [3:0] ALU_DIV   = 4'b0100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the execute stage (master) and muldiv_seq (slave).
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       aluCtr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic             div_zero;

  modport master (
    output start, aluCtr, A, B,
    input  busy, done, out, hi, div_zero
  );

  modport slave (
    input  start, aluCtr, A, B,
    output busy, done, out, hi, div_zero
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiply / restoring divide datapath, one bit per step.
// hi_r holds the partial high product or the remainder; lo_r the multiplier or quotient.
module muldiv_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi
);

  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d, b_q;
  logic [WIDTH:0]   sum, shifted, trial;

  always_comb begin
    sum     = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    hi_d    = {1'b0, sum[WIDTH:1]};
    lo_d    = {sum[0], lo_q[WIDTH-1:1]};
    if (op_div) begin
      // Negative trial (top bit set) means restore the shifted remainder.
      if (!trial[WIDTH]) begin
        hi_d = trial;
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted;
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign nxt_lo = lo_d;
  assign nxt_hi = hi_d[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= a;
      b_q  <= b;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide unit beside the single-cycle ALU.
// Results are registered on completion and held until the next completion or reset.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  MUL_CODE = ALU_MUL,
  parameter logic [3:0]  DIV_CODE = ALU_DIV
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic             op_div_q;
  logic [WIDTH-1:0] out_q, hi_q;
  logic             div_zero_q;

  logic             is_mul, is_div, b_zero, accept, div0, last;
  logic             load, step, busy, done;
  logic [WIDTH-1:0] nxt_lo, nxt_hi;

  assign is_mul = (bus.aluCtr == MUL_CODE);
  assign is_div = (bus.aluCtr == DIV_CODE);
  assign b_zero = (bus.B == '0);
  assign accept = (state_q == StIdle) && bus.start && (is_mul || is_div);
  assign div0   = accept && is_div && b_zero;
  assign last   = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = div0 ? StDone : StRun;
      StRun:  if (last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    load = accept && !div0;
    step = busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      out_q      <= '0;
      hi_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      if (load) begin
        cnt_q    <= '0;
        op_div_q <= is_div;
      end else if (step) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (accept) div_zero_q <= div0;
      // The last step's result is taken straight from the datapath's next value.
      if (div0) begin
        out_q <= '1;
        hi_q  <= bus.A;
      end else if (step && last) begin
        out_q <= nxt_lo;
        hi_q  <= nxt_hi;
      end
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .op_div (op_div_q),
    .a      (bus.A),
    .b      (bus.B),
    .nxt_lo (nxt_lo),
    .nxt_hi (nxt_hi)
  );

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.out      = out_q;
  assign bus.hi       = hi_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: cycle model from plain arithmetic plus directed literal checks.
module tb_muldiv_seq;
  localparam int unsigned W   = 32;
  localparam logic [3:0]  MUL = 4'b0011;
  localparam logic [3:0]  DIV = 4'b0100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(
    .WIDTH    (W),
    .MUL_CODE (MUL),
    .DIV_CODE (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: cycles of RUN left, pending result, and the visible output registers.
  int             run_left = 0;
  bit             m_done = 0, m_dz = 0, m_valid = 0;
  logic [W-1:0]   m_out = '0, m_hi = '0, p_out = '0, p_hi = '0;
  logic [2*W-1:0] prod;

  always @(posedge clk) begin
    if (reset) begin
      run_left = 0; m_done = 0; m_out = '0; m_hi = '0; m_dz = 0; m_valid = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        m_done = 1; m_out = p_out; m_hi = p_hi;
      end
    end else if (bus.start && (bus.aluCtr == MUL || bus.aluCtr == DIV)) begin
      m_dz = 0;
      if (bus.aluCtr == DIV && bus.B == 0) begin
        m_done = 1; m_out = '1; m_hi = bus.A; m_dz = 1;
      end else begin
        if (bus.aluCtr == MUL) begin
          prod  = {{W{1'b0}}, bus.A} * {{W{1'b0}}, bus.B};
          p_out = prod[W-1:0];
          p_hi  = prod[2*W-1:W];
        end else begin
          p_out = bus.A / bus.B;
          p_hi  = bus.A % bus.B;
        end
        run_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (bus.busy !== (run_left > 0) || bus.done !== m_done || bus.out !== m_out ||
          bus.hi !== m_hi || bus.div_zero !== m_dz) begin
        failures++;
        $display("FAIL cycle_model t=%0t got busy=%b done=%b out=%h hi=%h dz=%b want busy=%b done=%b out=%h hi=%h dz=%b",
                 $time, bus.busy, bus.done, bus.out, bus.hi, bus.div_zero,
                 (run_left > 0), m_done, m_out, m_hi, m_dz);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one op; returns edges from accept to done and the number of busy cycles seen.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n, output int bc);
    @(negedge clk);
    bus.start = 1'b1; bus.aluCtr = c; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; bc = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) bc++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.done) begin
      failures++;
      $display("FAIL done_timeout got=no_done want=done_within_100");
    end
  endtask

  int n, bc, dones;

  initial begin
    bus.start = 1'b0; bus.aluCtr = 4'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_dz", bus.div_zero, 0);

    run_op(MUL, 7, 6, n, bc);
    chk("mul_lat", n, W);
    chk("mul_busy_cycles", bc, W);
    chk("mul_out", bus.out, 42);
    chk("mul_hi", bus.hi, 0);
    chk("mul_dz", bus.div_zero, 0);

    run_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, bc);
    chk("mulmax_out", bus.out, 32'h0000_0001);
    chk("mulmax_hi", bus.hi, 32'hFFFF_FFFE);

    run_op(DIV, 100, 7, n, bc);
    chk("div_lat", n, W);
    chk("div_out", bus.out, 14);
    chk("div_hi", bus.hi, 2);

    run_op(DIV, 5, 9, n, bc);
    chk("divsmall_out", bus.out, 0);
    chk("divsmall_hi", bus.hi, 5);

    run_op(DIV, 32'h1234, 0, n, bc);
    chk("div0_lat", n, 0);
    chk("div0_busy_cycles", bc, 0);
    chk("div0_out", bus.out, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'h1234);
    chk("div0_dz", bus.div_zero, 1);

    run_op(MUL, 2, 3, n, bc);
    chk("mul_after_div0_dz", bus.div_zero, 0);
    chk("mul_after_div0_out", bus.out, 6);

    @(negedge clk);
    bus.start = 1'b1; bus.aluCtr = 4'b0010; bus.A = 9; bus.B = 9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bad_code_busy", bus.busy, 0);
      chk("bad_code_done", bus.done, 0);
    end
    bus.start = 1'b0;
    chk("bad_code_out", bus.out, 6);

    // start held through the op with operands and code changed after accept
    @(negedge clk);
    bus.start = 1'b1; bus.aluCtr = MUL; bus.A = 1000; bus.B = 1000;
    @(negedge clk);
    bus.A = 5; bus.B = 9; bus.aluCtr = DIV;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        dones++;
        chk("held_out", bus.out, 1000000);
        chk("held_hi", bus.hi, 0);
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("held_done_count", dones, 1);

    @(negedge clk);
    bus.start = 1'b1; bus.aluCtr = MUL; bus.A = 9; bus.B = 9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_out", bus.out, 0);
    chk("midrst_hi", bus.hi, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    chk("midrst_no_done", dones, 0);

    run_op(MUL, 3, 3, n, bc);
    chk("after_rst_out", bus.out, 9);
    chk("after_rst_hi", bus.hi, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
